sd_adc_frontend: RTL and testbench

- RTL front end for one sigma-delta ADC channel (external comparator plus RC integrator).
- Samples the comparator output `sd` every clock and drives it back as the 1-bit feedback `pcm`.
- Decimates the bitstream with a boxcar ones-counter into an 8-bit sample stream.
- Runs an arm/hit/clear threshold detector that timestamps the first qualified crossing, for shot timing by downstream logic.

---
 rtl/sd_adc_pkg.sv | 26 ++
 rtl/sd_adc_frontend_decim.sv | 73 +++++++
 rtl/sd_adc_frontend.sv | 101 ++++++++++
 tb/tb_sd_adc_frontend.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sd_adc_pkg.sv
// Shared types and helpers for the sigma-delta ADC front end.
package sd_adc_pkg;

   localparam int unsigned SAMPLE_W   = 8;
   localparam int unsigned SAMPLE_MAX = (1 << SAMPLE_W) - 1;

   // Threshold detector states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      HIT   = 2'd2
   } det_state_e;

   // Scale a window ones-count to an 8-bit sample: ones*256/DECIM, saturated.
   // DECIM is a power of two, so the divide is a right shift by log2(DECIM).
   function automatic logic [SAMPLE_W-1:0] scale_ones(input logic [31:0] ones,
                                                      input int unsigned decim_log2);
      logic [31:0] scaled;
      scaled = (ones << SAMPLE_W) >> decim_log2;
      if (scaled > 32'(SAMPLE_MAX)) begin
         scaled = 32'(SAMPLE_MAX);
      end
      return scaled[SAMPLE_W-1:0];
   endfunction

endpackage

// File: rtl/sd_adc_frontend_decim.sv
// Feedback flop plus boxcar ones-counter decimator for one sigma-delta channel.
// The comparator bit is registered exactly once: that flop is both the loop
// feedback (pcm) and the only copy of the bitstream used for counting.
module sd_decim
   import sd_adc_pkg::*;
#(
   parameter int unsigned DECIM = 256
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                sd,
   output logic                pcm,
   output logic [SAMPLE_W-1:0] sample,
   output logic                sample_valid
);

   localparam int unsigned WC_W   = $clog2(DECIM);
   localparam int unsigned ONES_W = WC_W + 1;

   logic                sd_q;
   logic                primed_q;
   logic [WC_W-1:0]     wc_q,     wc_d;
   logic [ONES_W-1:0]   ones_q,   ones_d;
   logic [SAMPLE_W-1:0] sample_q, sample_d;
   logic                valid_q,  valid_d;
   logic [ONES_W-1:0]   total;

   // Window bookkeeping; counting starts only once sd_q holds a real sample.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can leave a latch.
      wc_d     = wc_q;
      ones_d   = ones_q;
      sample_d = sample_q;
      valid_d  = 1'b0;
      total    = ones_q + ONES_W'(sd_q);
      if (primed_q) begin
         if (wc_q == WC_W'(DECIM - 1)) begin
            wc_d     = '0;
            ones_d   = '0;
            sample_d = scale_ones(32'(total), WC_W);
            valid_d  = 1'b1;
         end else begin
            wc_d   = wc_q + WC_W'(1);
            ones_d = total;
         end
      end
   end

   // Feedback flop and decimator state; a reset discards any partial window.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: state is updated with <= so every flop samples the pre-edge values.
      if (!reset_n) begin
         sd_q     <= 1'b0;
         primed_q <= 1'b0;
         wc_q     <= '0;
         ones_q   <= '0;
         sample_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         sd_q     <= sd;
         primed_q <= 1'b1;
         wc_q     <= wc_d;
         ones_q   <= ones_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
      end
   end

   assign pcm          = sd_q;
   assign sample       = sample_q;
   assign sample_valid = valid_q;

endmodule

// File: rtl/sd_adc_frontend.sv
// Sigma-delta ADC channel front end: feedback, decimation and an
// arm/hit/clear threshold detector that timestamps the qualifying sample.
module sd_adc_frontend
   import sd_adc_pkg::*;
#(
   parameter int unsigned DECIM = 256,
   parameter int unsigned HITS  = 2,
   parameter int unsigned TS_W  = 32
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                sd,
   output logic                pcm,
   output logic [SAMPLE_W-1:0] sample,
   output logic                sample_valid,
   input  logic [SAMPLE_W-1:0] threshold,
   input  logic                arm,
   input  logic                clear,
   output logic                armed,
   output logic                hit,
   output logic [TS_W-1:0]     hit_ts
);

   det_state_e      state_q, state_d;
   logic [3:0]      run_q,   run_d;
   logic [3:0]      run_inc;
   logic [TS_W-1:0] ts_q;
   logic [TS_W-1:0] hit_ts_q, hit_ts_d;
   logic            armed_q, hit_q;

   sd_decim #(
      .DECIM        (DECIM)
   ) u_decim (
      .clk          (clk),
      .reset_n      (reset_n),
      .sd           (sd),
      .pcm          (pcm),
      .sample       (sample),
      .sample_valid (sample_valid)
   );

   // Detector next state: clear wins over arm and over a same-cycle qualification.
   always_comb begin
      state_d  = state_q;
      run_d    = run_q;
      hit_ts_d = hit_ts_q;
      run_inc  = run_q + 4'd1;
      if (clear) begin
         state_d = IDLE;
         run_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arm) begin
                  state_d = ARMED;
                  run_d   = '0;
               end
            end
            ARMED: begin
               if (sample_valid) begin
                  if (sample > threshold) begin
                     run_d = run_inc;
                     if (run_inc == 4'(HITS)) begin
                        state_d  = HIT;
                        hit_ts_d = ts_q;
                     end
                  end else begin
                     run_d = '0;
                  end
               end
            end
            HIT:     ;
            default: state_d = IDLE;
         endcase
      end
   end

   // Detector state, registered status decodes, and the free-running timestamp.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         run_q    <= '0;
         ts_q     <= '0;
         hit_ts_q <= '0;
         armed_q  <= 1'b0;
         hit_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         run_q    <= run_d;
         ts_q     <= ts_q + TS_W'(1);
         hit_ts_q <= hit_ts_d;
         armed_q  <= (state_d == ARMED);
         hit_q    <= (state_d == HIT);
      end
   end

   assign armed  = armed_q;
   assign hit    = hit_q;
   assign hit_ts = hit_ts_q;

endmodule

// File: tb/tb_sd_adc_frontend.sv
// Directed bench for sd_adc_frontend (DECIM=256, HITS=2, TS_W=32).
// Each 256-clock window is driven by run_window; the result of a window is
// observed on the first edge of the following run_window call.
module tb_sd_adc_frontend;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        sd;
   logic        pcm;
   logic [7:0]  sample;
   logic        sample_valid;
   logic [7:0]  threshold;
   logic        arm;
   logic        clear;
   logic        armed;
   logic        hit;
   logic [31:0] hit_ts;

   int checks   = 0;
   int failures = 0;

   // Values captured during the most recent run_window call.
   logic        pcm0, v0, v1, vlast, hit0, hit1, armed0, armed1, hit_any;
   logic [7:0]  smp0;
   logic [31:0] hts1;
   int          nvalid;
   int          integ;

   sd_adc_frontend #(
      .DECIM        (256),
      .HITS         (2),
      .TS_W         (32)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sd           (sd),
      .pcm          (pcm),
      .sample       (sample),
      .sample_valid (sample_valid),
      .threshold    (threshold),
      .arm          (arm),
      .clear        (clear),
      .armed        (armed),
      .hit          (hit),
      .hit_ts       (hit_ts)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Assert reset for two edges, then release #1 after an edge so the next edge is clock 1.
   task automatic do_reset();
      @(posedge clk); #1;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      integ   = 0;
      reset_n = 1'b1;
   endtask

   // One window of sd: mode>=0 gives that many leading ones, -1 toggles, -2 closed loop.
   task automatic run_window(input int mode);
      nvalid  = 0;
      hit_any = 1'b0;
      for (int i = 0; i < 256; i++) begin
         if (mode == -1) begin
            sd = i[0];
         end else if (mode == -2) begin
            integ = integ + 32768 - (pcm ? 65536 : 0);
            sd    = (integ > 0);
         end else begin
            sd = (i < mode);
         end
         @(posedge clk); #1;
         if (i == 0) begin
            arm    = 1'b0;
            pcm0   = pcm;
            v0     = sample_valid;
            smp0   = sample;
            hit0   = hit;
            armed0 = armed;
         end
         if (i == 1) begin
            v1     = sample_valid;
            hit1   = hit;
            armed1 = armed;
            hts1   = hit_ts;
         end
         if (i == 255) vlast = sample_valid;
         nvalid  = nvalid + int'(sample_valid);
         hit_any = hit_any | hit;
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      sd        = 1'b1;
      arm       = 1'b0;
      clear     = 1'b0;
      threshold = 8'd200;
      integ     = 0;

      // ---- sd held 1 from reset, then 0, then toggling ----
      do_reset();
      check("rst_pcm",    pcm,          0);
      check("rst_sample", sample,       0);
      check("rst_valid",  sample_valid, 0);
      check("rst_armed",  armed,        0);
      check("rst_hit",    hit,          0);
      check("rst_hit_ts", hit_ts,       0);
      run_window(256);
      check("ones_pcm_after_1clk", pcm0,   1);
      check("ones_no_valid_256",   vlast,  0);
      check("ones_w0_nvalid",      nvalid, 0);
      run_window(256);
      check("ones_valid_257",  v0,     1);
      check("ones_sample",     smp0,   255);
      check("ones_pulse_1clk", v1,     0);
      check("ones_w1_nvalid",  nvalid, 1);
      run_window(0);
      check("ones_sample_w1",  smp0,   255);
      check("ones_w2_nvalid",  nvalid, 1);
      run_window(-1);
      check("zeros_sample",    smp0,   0);
      run_window(0);
      check("toggle_sample",   smp0,   128);
      check("unarmed_no_hit",  hit_any, 0);

      // ---- closed loop at midscale, armed, threshold 200 ----
      arm = 1'b1;
      do_reset();
      for (int w = 0; w < 6; w++) begin
         run_window(-2);
         if (w >= 2) begin
            check($sformatf("loop_in_range_w%0d", w - 1),
                  (smp0 >= 8'd126) && (smp0 <= 8'd130), 1);
            check($sformatf("loop_no_hit_w%0d", w - 1), hit_any, 0);
         end
      end
      check("loop_still_armed", armed, 1);

      // ---- hit qualification: 210, 150, 210, 220 ----
      arm = 1'b1;
      sd  = 1'b0;
      do_reset();
      run_window(210);
      check("q_armed_after_arm", armed0, 1);
      run_window(150);
      check("q_s0", smp0, 210);
      check("q_no_hit_s0", hit_any, 0);
      run_window(210);
      check("q_s1", smp0, 150);
      check("q_no_hit_s1", hit_any, 0);
      run_window(220);
      check("q_s2", smp0, 210);
      check("q_no_hit_s2", hit_any, 0);
      run_window(0);
      check("q_s3",             smp0,   220);
      check("q_hit_not_early",  hit0,   0);
      check("q_hit_next_cycle", hit1,   1);
      check("q_armed_dropped",  armed1, 0);
      check("q_hit_ts",         hts1,   1025);
      arm = 1'b1;
      run_window(256);
      check("q_hit_held",    hit,    1);
      check("q_hit_ts_held", hit_ts, 1025);
      check("q_arm_ignored", armed,  0);

      // ---- clear beats arm in HIT, then arm alone ----
      clear = 1'b1;
      arm   = 1'b1;
      @(posedge clk); #1;
      check("clr_hit",   hit,   0);
      check("clr_armed", armed, 0);
      clear = 1'b0;
      @(posedge clk); #1;
      check("rearm_armed", armed, 1);
      check("rearm_hit",   hit,   0);
      arm = 1'b0;

      // ---- async reset mid-window while armed ----
      sd = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("mid_rst_pcm",    pcm,          0);
      check("mid_rst_sample", sample,       0);
      check("mid_rst_valid",  sample_valid, 0);
      check("mid_rst_armed",  armed,        0);
      check("mid_rst_hit",    hit,          0);
      check("mid_rst_hit_ts", hit_ts,       0);
      arm       = 1'b1;
      threshold = 8'd255;
      do_reset();
      run_window(256);
      check("post_rst_no_valid",  nvalid, 0);
      check("post_rst_armed",     armed0, 1);
      run_window(256);
      check("post_rst_valid_257", v0,     1);
      check("post_rst_sample",    smp0,   255);
      check("thr255_no_hit_a",    hit_any, 0);
      run_window(256);
      check("thr255_no_hit_b",    hit_any, 0);
      check("thr255_still_armed", armed,   1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
